// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-in/first-out buffer with first-word
//            fall-through read data. Status flags are decoded from the
//            registered pointers only. Writes are dropped when full and
//            reads are ignored when empty.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_WIDTH  width of each stored word
//   DEPTH       number of entries (power of two, >= 2)
// Ports:
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous, active-high reset
//   wen        in   1           write request (accepted when not full)
//   ren        in   1           read request (accepted when not empty)
//   wdata      in   DATA_WIDTH  write data
//   rdata      out  DATA_WIDTH  head entry, 0 while empty
//   empty      out  1           FIFO holds no entries
//   full       out  1           FIFO holds DEPTH entries
//   overflow   out  1           sticky: write seen while full
//   underflow  out  1           sticky: read seen while empty
// Build option:
//   FIFO_ERR_FLAGS_EN  when defined, adds the overflow/underflow outputs.
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int          c_ADDR_W  = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_PTR_ONE = {{c_ADDR_W{1'b0}}, 1'b1};

  // Storage has no reset; only the pointers define what is valid.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits coincide.
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                   (r_wr_ptr[c_ADDR_W]     != r_rd_ptr[c_ADDR_W]);

  // Each request is qualified against the flags as they stand this cycle,
  // so a simultaneous read never frees room for a write in the same edge.
  assign w_wr_acc = wen & ~w_full;
  assign w_rd_acc = ren & ~w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= wdata;
    end
  end

  // Fall-through read: the head is shown from registered state only, so
  // there is no path from wdata or the request inputs to rdata.
  assign rdata = w_empty ? '0 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign empty = w_empty;
  assign full  = w_full;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wen && w_full)  r_overflow  <= 1'b1;
      if (ren && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Directed self-checking bench for sync_fifo (DATA_WIDTH=4,
//            DEPTH=16). Inputs change 1 time unit after the rising edge and
//            outputs are sampled at the same point.
// Revision : 1.0 - initial release
// Build option:
//   FIFO_ERR_FLAGS_EN  when defined, the sticky error flags are also checked.
// ============================================================================
`timescale 1ns/1ps
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wen;
  logic       ren;
  logic [3:0] wdata;
  logic [3:0] rdata;
  logic       empty;
  logic       full;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_total;
  int n_bad;

  logic [3:0] q_model [$];

  sync_fifo #(
    .DATA_WIDTH(4),
    .DEPTH     (16)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .wen      (wen),
    .ren      (ren),
    .wdata    (wdata),
    .rdata    (rdata),
    .empty    (empty),
    .full     (full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    wen     = 1'b0;
    ren     = 1'b0;
    wdata   = 4'h0;

    // ---------------- reset ----------------
    repeat (6) step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("rst_ovf", 32'(overflow),  32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
`endif
    reset = 1'b0;
    step();
    check("idle_empty", 32'(empty), 32'd1);

    // ---------------- fill past capacity ----------------
    for (int i = 0; i < 18; i++) begin
      wen   = 1'b1;
      wdata = 4'(i);
      step();
      check("fill_full",  32'(full),  (i >= 15) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(empty), 32'd0);
      check("fill_head",  32'(rdata), 32'd0);
    end
    wen = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    check("fill_ovf", 32'(overflow),  32'd1);
    check("fill_udf", 32'(underflow), 32'd0);
`endif

    // ---------------- drain past empty ----------------
    for (int i = 0; i < 18; i++) begin
      ren = 1'b1;
      check("drain_rdata", 32'(rdata), (i < 16) ? 32'(i) : 32'd0);
      check("drain_full",  32'(full),  (i == 0) ? 32'd1 : 32'd0);
      step();
      check("drain_empty", 32'(empty), (i >= 15) ? 32'd1 : 32'd0);
    end
    ren = 1'b0;
    check("drain_rdata_end", 32'(rdata), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("drain_udf", 32'(underflow), 32'd1);
    check("drain_ovf_hold", 32'(overflow), 32'd1);
`endif

    // ---------------- simultaneous access with 3 queued ----------------
    for (int i = 0; i < 3; i++) begin
      wen   = 1'b1;
      wdata = 4'(5 + i);
      q_model.push_back(4'(5 + i));
      step();
    end
    for (int i = 0; i < 20; i++) begin
      wen   = 1'b1;
      ren   = 1'b1;
      wdata = 4'(8 + 3 * i);
      check("sim_rdata", 32'(rdata), 32'(q_model[0]));
      void'(q_model.pop_front());
      q_model.push_back(4'(8 + 3 * i));
      step();
      check("sim_empty", 32'(empty), 32'd0);
      check("sim_full",  32'(full),  32'd0);
    end
    wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ren = 1'b1;
      check("sim_tail", 32'(rdata), 32'(q_model[0]));
      void'(q_model.pop_front());
      step();
    end
    ren = 1'b0;
    check("sim_occupancy_empty", 32'(empty), 32'd1);

    // ---------------- boundary: wen+ren while empty ----------------
    wen   = 1'b1;
    ren   = 1'b1;
    wdata = 4'h9;
    step();
    ren = 1'b0;
    check("bnd_e_empty", 32'(empty), 32'd0);
    check("bnd_e_rdata", 32'(rdata), 32'h9);
    // top up to full: 9 then 1..15
    for (int i = 1; i < 16; i++) begin
      wdata = 4'(i);
      step();
    end
    check("bnd_f_full", 32'(full), 32'd1);
    // ---------------- boundary: wen+ren while full ----------------
    wen   = 1'b1;
    ren   = 1'b1;
    wdata = 4'hF;
    check("bnd_f_head", 32'(rdata), 32'h9);
    step();
    wen = 1'b0;
    ren = 1'b0;
    check("bnd_f_full_clr", 32'(full), 32'd0);
    check("bnd_f_next", 32'(rdata), 32'h1);
    // remaining 15 entries are 1..15; the 0xF write must not appear after them
    for (int i = 1; i < 16; i++) begin
      ren = 1'b1;
      check("bnd_drain", 32'(rdata), 32'(i));
      step();
    end
    ren = 1'b0;
    check("bnd_no_extra", 32'(empty), 32'd1);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      wen   = 1'b1;
      wdata = 4'(10 + i);
      step();
    end
    check("mid_pre_empty", 32'(empty), 32'd0);
    reset = 1'b1;
    wen   = 1'b1;
    wdata = 4'h3;
    step();
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_full",  32'(full),  32'd0);
    check("mid_rdata", 32'(rdata), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("mid_ovf", 32'(overflow),  32'd0);
    check("mid_udf", 32'(underflow), 32'd0);
`endif
    reset = 1'b0;
    wen   = 1'b0;
    step();
    check("mid_post_empty", 32'(empty), 32'd1);
    check("mid_post_rdata", 32'(rdata), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
